// File: rtl/lockstep_pkg.sv
// Shared types and default parameters for the lockstep pair controller.
package lockstep_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } lockstep_state_e;

  localparam logic [31:0] DEF_BOOT_ADDR    = 32'h0000_0000;
  localparam int unsigned DEF_INSTR_COUNT  = 32'd16;
  localparam int unsigned DEF_DRAIN_CYCLES = 32'd4;
  localparam int unsigned DEF_MAX_CYCLES   = 32'd1024;

endpackage

// File: rtl/lockstep_clk_gate.sv
// Glitch-free clock gate: enable is captured in the low phase, then ANDed with the clock.
module lockstep_clk_gate (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic clk_o,
  output logic en_q_o
);

  logic en_q_r;

  // Low-phase enable latch-equivalent; reset keeps the core clock running
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q_r <= 1'b1;
    end else begin
      en_q_r <= en_i;
    end
  end

  assign clk_o  = clk_i & en_q_r;
  assign en_q_o = en_q_r;

endmodule

// File: rtl/lockstep_pair_ctrl.sv
// Keeps two cores retiring in lockstep, tracks clock-trace equivalence and
// ends the run once both cores have fetched past the program.
module lockstep_pair_ctrl
  import lockstep_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR    = DEF_BOOT_ADDR,
  parameter int unsigned INSTR_COUNT  = DEF_INSTR_COUNT,
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        retire_1_i,
  input  logic        retire_2_i,
  input  logic        fetch_1_i,
  input  logic        fetch_2_i,
  input  logic [31:0] instr_addr_1_i,
  input  logic [31:0] instr_addr_2_i,
  output logic        clk_1_o,
  output logic        clk_2_o,
  output logic        retire_o,
  output logic        enable_1_o,
  output logic        enable_2_o,
  output logic        finished_o,
  output logic        atk_equiv_o
);

  localparam logic [31:0] PROG_SPAN  = 32'd4 * 32'(INSTR_COUNT);
  localparam logic [31:0] CYCLE_LAST = 32'(MAX_CYCLES) - 32'd1;
  localparam logic [31:0] DRAIN_LAST = (DRAIN_CYCLES == 32'd0) ? 32'd0
                                                               : 32'(DRAIN_CYCLES) - 32'd1;

  lockstep_state_e state_r, state_next_s;
  logic [31:0] drain_cnt_r;
  logic [31:0] cycle_cnt_r;
  logic        finished_r;
  logic        atk_equiv_r;
  logic        enable_1_r, enable_2_r;
  logic        en_1_s, en_2_s;
  logic        en_1_q_s, en_2_q_s;
  logic        oob_1_s, oob_2_s;
  logic        timeout_s;

  // The core that retires alone is frozen until its partner retires too
  assign en_1_s = !finished_r && !(retire_1_i && !retire_2_i);
  assign en_2_s = !finished_r && !(retire_2_i && !retire_1_i);

  lockstep_clk_gate u_gate_1 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_1_s),
    .clk_o  (clk_1_o),
    .en_q_o (en_1_q_s)
  );

  lockstep_clk_gate u_gate_2 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_2_s),
    .clk_o  (clk_2_o),
    .en_q_o (en_2_q_s)
  );

  // Offset form covers both below-boot (wraps large) and past-end addresses
  assign oob_1_s   = fetch_1_i && ((instr_addr_1_i - BOOT_ADDR) >= PROG_SPAN);
  assign oob_2_s   = fetch_2_i && ((instr_addr_2_i - BOOT_ADDR) >= PROG_SPAN);
  assign timeout_s = (cycle_cnt_r >= CYCLE_LAST);

  // Next-state logic; timeout overrides every state
  always_comb begin
    state_next_s = state_r;
    if (timeout_s) begin
      state_next_s = DONE;
    end else begin
      case (state_r)
        RUN: begin
          if (!enable_1_r && !enable_2_r) begin
            state_next_s = DRAIN;
          end else begin
            state_next_s = RUN;
          end
        end
        DRAIN: begin
          if (drain_cnt_r >= DRAIN_LAST) begin
            state_next_s = DONE;
          end else begin
            state_next_s = DRAIN;
          end
        end
        DONE:    state_next_s = DONE;
        default: state_next_s = DONE;
      endcase
    end
  end

  // FSM state and drain counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= RUN;
      drain_cnt_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      if (state_r != DRAIN) begin
        drain_cnt_r <= 32'd0;
      end else if (drain_cnt_r != DRAIN_LAST) begin
        drain_cnt_r <= drain_cnt_r + 32'd1;
      end else begin
        drain_cnt_r <= drain_cnt_r;
      end
    end
  end

  // Run-time counter, saturating at the timeout threshold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_r <= 32'd0;
    end else if (cycle_cnt_r != CYCLE_LAST) begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  // Sticky status flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      finished_r  <= 1'b0;
      atk_equiv_r <= 1'b1;
      enable_1_r  <= 1'b1;
      enable_2_r  <= 1'b1;
    end else begin
      finished_r  <= finished_r | (state_next_s == DONE);
      atk_equiv_r <= atk_equiv_r & !((en_1_q_s != en_2_q_s) && !finished_r);
      enable_1_r  <= enable_1_r & !oob_1_s;
      enable_2_r  <= enable_2_r & !oob_2_s;
    end
  end

  assign retire_o    = retire_1_i & retire_2_i & !finished_r;
  assign finished_o  = finished_r;
  assign atk_equiv_o = atk_equiv_r;
  assign enable_1_o  = enable_1_r;
  assign enable_2_o  = enable_2_r;

endmodule

// File: tb/tb_lockstep_pair_ctrl.sv
// Directed bench for lockstep_pair_ctrl with a cycle-level reference model.
module tb_lockstep_pair_ctrl;

  localparam logic [31:0] BOOT     = 32'h0000_0000;
  localparam int          ICOUNT   = 16;
  localparam int          DRAIN    = 4;
  localparam int          MAXC     = 1024;
  localparam logic [31:0] END_ADDR = BOOT + 32'(4 * ICOUNT);

  logic        clk_i, rst_ni;
  logic        retire_1_i, retire_2_i, fetch_1_i, fetch_2_i;
  logic [31:0] instr_addr_1_i, instr_addr_2_i;
  logic        clk_1_o, clk_2_o, retire_o, enable_1_o, enable_2_o, finished_o, atk_equiv_o;

  lockstep_pair_ctrl #(
    .BOOT_ADDR    (BOOT),
    .INSTR_COUNT  (ICOUNT),
    .DRAIN_CYCLES (DRAIN),
    .MAX_CYCLES   (MAXC)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .retire_1_i     (retire_1_i),
    .retire_2_i     (retire_2_i),
    .fetch_1_i      (fetch_1_i),
    .fetch_2_i      (fetch_2_i),
    .instr_addr_1_i (instr_addr_1_i),
    .instr_addr_2_i (instr_addr_2_i),
    .clk_1_o        (clk_1_o),
    .clk_2_o        (clk_2_o),
    .retire_o       (retire_o),
    .enable_1_o     (enable_1_o),
    .enable_2_o     (enable_2_o),
    .finished_o     (finished_o),
    .atk_equiv_o    (atk_equiv_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the visible state during cycle m_k (cycles counted from reset release)
  int   m_k;
  int   m_both_low;
  logic m_clk1, m_clk2, m_en1, m_en2, m_eq, m_fin;

  // Values observed in the most recent cycle, for the hand-computed checks
  int   obs_k;
  logic obs_clk1, obs_clk2, obs_ret, obs_fin, obs_eq, obs_en1, obs_en2;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic out_of_range(input logic [31:0] a);
    return (longint'(a) >= longint'(END_ADDR)) || (longint'(a) < longint'(BOOT));
  endfunction

  task automatic model_reset();
    m_k = 0; m_both_low = -1;
    m_clk1 = 1'b1; m_clk2 = 1'b1;
    m_en1 = 1'b1; m_en2 = 1'b1; m_eq = 1'b1; m_fin = 1'b0;
  endtask

  // Called at posedge+2: drive one cycle, compare at posedge+4 (clock high), advance model
  task automatic run_cycle(input logic r1, input logic r2, input logic f1, input logic [31:0] a1,
                           input logic f2, input logic [31:0] a2);
    logic run1, run2;
    retire_1_i = r1; retire_2_i = r2;
    fetch_1_i = f1; instr_addr_1_i = a1;
    fetch_2_i = f2; instr_addr_2_i = a2;
    #2;
    obs_k = m_k; obs_clk1 = clk_1_o; obs_clk2 = clk_2_o; obs_ret = retire_o;
    obs_fin = finished_o; obs_eq = atk_equiv_o; obs_en1 = enable_1_o; obs_en2 = enable_2_o;
    check("clk_1_o", clk_1_o, m_clk1);
    check("clk_2_o", clk_2_o, m_clk2);
    check("retire_o", retire_o, r1 & r2 & !m_fin);
    check("enable_1_o", enable_1_o, m_en1);
    check("enable_2_o", enable_2_o, m_en2);
    check("atk_equiv_o", atk_equiv_o, m_eq);
    check("finished_o", finished_o, m_fin);
    // A core runs next cycle unless it retired alone or the run is over
    run1 = !m_fin && !(r1 && !r2);
    run2 = !m_fin && !(r2 && !r1);
    if ((run1 != run2) && !m_fin) m_eq = 1'b0;
    if (f1 && out_of_range(a1)) m_en1 = 1'b0;
    if (f2 && out_of_range(a2)) m_en2 = 1'b0;
    m_k++;
    m_clk1 = run1; m_clk2 = run2;
    if (m_both_low < 0 && !m_en1 && !m_en2) m_both_low = m_k;
    m_fin = (m_k >= MAXC) || (m_both_low >= 0 && m_k >= m_both_low + DRAIN + 1);
    @(posedge clk_i); #2;
  endtask

  task automatic idle();
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    retire_1_i = 1'b0; retire_2_i = 1'b0; fetch_1_i = 1'b0; fetch_2_i = 1'b0;
    instr_addr_1_i = 32'h0; instr_addr_2_i = 32'h0;
    rst_ni = 1'b0;
    model_reset();
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    int low1, rets, tcyc;
    rst_ni = 1'b0;
    retire_1_i = 1'b0; retire_2_i = 1'b0; fetch_1_i = 1'b0; fetch_2_i = 1'b0;
    instr_addr_1_i = 32'h0; instr_addr_2_i = 32'h0;
    @(posedge clk_i); #2;

    // Reset release, idle
    do_reset();
    idle();
    check("rst_clk_1", obs_clk1, 1'b1);
    check("rst_clk_2", obs_clk2, 1'b1);
    check("rst_equiv", obs_eq, 1'b1);
    check("rst_enable_1", obs_en1, 1'b1);
    check("rst_enable_2", obs_en2, 1'b1);
    check("rst_finished", obs_fin, 1'b0);
    idle(); idle();

    // Core 1 runs ahead for three retires, then both retire together
    low1 = 0; rets = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      else if (i == 3) run_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      else idle();
      if (!obs_clk1) low1++;
      if (obs_ret) rets++;
    end
    check("slip_clk1_low_cycles", low1, 32'd3);
    check("slip_retire_pulses", rets, 32'd1);
    check("slip_equiv_cleared", obs_eq, 1'b0);
    idle();
    check("slip_equiv_sticky", obs_eq, 1'b0);

    // Perfect lockstep for 20 cycles
    do_reset();
    rets = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      if (obs_ret) rets++;
    end
    check("lock_retire_count", rets, 32'd20);
    check("lock_equiv", obs_eq, 1'b1);

    // Fetch boundary, ignored non-fetch, then drain to completion
    run_cycle(1'b0, 1'b0, 1'b1, 32'h3C, 1'b0, 32'h0);
    idle();
    check("last_word_enable_1", obs_en1, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h80);
    idle();
    check("end_fetch_enable_1", obs_en1, 1'b0);
    check("no_fetch_enable_2", obs_en2, 1'b1);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    tcyc = obs_k;
    for (int j = 1; j <= 8; j++) begin
      run_cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      check("drain_finished_timing", {obs_fin, 31'(obs_k - tcyc)},
            {((obs_k - tcyc) >= DRAIN + 2), 31'(j)});
    end
    check("done_clk_1_stopped", obs_clk1, 1'b0);
    check("done_clk_2_stopped", obs_clk2, 1'b0);
    check("done_retire_masked", obs_ret, 1'b0);

    // Asynchronous reset while draining, with core 1 frozen
    do_reset();
    run_cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    idle();
    run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("drain_clk_1_frozen", clk_1_o, 1'b0);
    check("drain_equiv_low", atk_equiv_o, 1'b0);
    check("drain_not_finished", finished_o, 1'b0);
    retire_1_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("arst_clk_1", clk_1_o, 1'b1);
    check("arst_clk_2", clk_2_o, 1'b1);
    check("arst_enable_1", enable_1_o, 1'b1);
    check("arst_enable_2", enable_2_o, 1'b1);
    check("arst_equiv", atk_equiv_o, 1'b1);
    check("arst_finished", finished_o, 1'b0);
    model_reset();
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    idle(); idle(); idle();

    // Core 2 never retires: timeout forces completion
    do_reset();
    for (int i = 0; i < MAXC + 3; i++) begin
      run_cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      if (obs_k == MAXC - 1) check("timeout_before", obs_fin, 1'b0);
      if (obs_k == MAXC) check("timeout_at_max", obs_fin, 1'b1);
    end
    check("timeout_clk_1", obs_clk1, 1'b0);
    check("timeout_clk_2", obs_clk2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lockstep_pair_ctrl.md
# lockstep_pair_ctrl

Lockstep controller for a two-core relational verification harness. It gates the clocks of two identical cores so that they retire instructions in the same cycle. It records whether an attacker watching clock activity could tell the two runs apart, and it stops instruction supply and flags completion when both cores have run past the end of the test program. It sits between the harness clock and the core/memory pairs; the contract checker consumes `retire_o`.

## Interface
Parameters:
- `BOOT_ADDR`, default 32'h0: address of the first program instruction.
- `INSTR_COUNT`, default 16: number of 32-bit instructions in the program. End address = `BOOT_ADDR + 4*INSTR_COUNT`.
- `DRAIN_CYCLES`, default 4: cycles to wait after both fetch enables fall before `finished_o` is raised.
- `MAX_CYCLES`, default 1024: timeout that forces `finished_o`.

Ports:
- `clk_i` in 1: harness clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `retire_1_i`, `retire_2_i` in 1: core N retires an instruction this cycle.
- `fetch_1_i`, `fetch_2_i` in 1: core N performs a real fetch this cycle (low while flushing).
- `instr_addr_1_i`, `instr_addr_2_i` in 32: core N fetch address.
- `clk_1_o`, `clk_2_o` out 1: gated core clocks.
- `retire_o` out 1: both cores retire this cycle.
- `enable_1_o`, `enable_2_o` out 1: instruction memory N supplies program words when high and NOPs when low.
- `finished_o` out 1: run complete; sticky.
- `atk_equiv_o` out 1: clock traces of the two cores identical so far; sticky-low.

## Operation
- Gate enables `en_1`/`en_2`:
  - Computed each cycle as follows:
    - `en_1 = !finished && !(retire_1_i && !retire_2_i)`.
    - `en_2 = !finished && !(retire_2_i && !retire_1_i)`.
  - A core that reaches retirement first is frozen until the other catches up.
  - Each enable is captured on the falling edge of `clk_i`.
  - `clk_N_o = clk_i & en_N_q`, so the gated clocks are glitch-free.
- `retire_o = retire_1_i & retire_2_i & !finished_o`, combinational.
- `atk_equiv_o`:
  - Reset 1.
  - Cleared on a rising edge of `clk_i` when `en_1_q != en_2_q` and `finished_o` is 0.
  - Once cleared, stays 0 until reset.
- `enable_N_o`:
  - Reset 1.
  - Cleared on a rising edge of `clk_i` when `fetch_N_i` is high and `instr_addr_N_i` is at or above the end address, or below `BOOT_ADDR`.
  - Sticky low until reset.
- Control FSM states: RUN → DRAIN → DONE.
  - RUN: moves to DRAIN when both enables are 0.
  - DRAIN: counts `DRAIN_CYCLES` harness cycles, then moves to DONE.
  - DONE: `finished_o` = 1 and both core clocks are stopped.
  - A free-running cycle counter reaching `MAX_CYCLES-1` moves the FSM to DONE from any state.
- Simultaneous retire on both cores: no gating, `retire_o` = 1.
- Neither core retiring: both clocks run.

## Timing
- All state uses asynchronous active-low reset. Reset values:
  - both `en_N_q` = 1 (clocks run);
  - `enable_N_o` = 1;
  - `atk_equiv_o` = 1;
  - `finished_o` = 0;
  - FSM = RUN;
  - counters = 0.
- Gating latency: a retire imbalance sampled in the high phase stops the lagging-ahead core's next rising edge. Zero cycles of slip.
- `enable_N_o` falls one `clk_i` cycle after the out-of-range fetch.
- `finished_o` rises exactly `DRAIN_CYCLES+1` cycles after the second enable falls.
- Reset asserted mid-run returns every output to its reset value immediately. Core clocks resume following `clk_i`.
- The counters saturate and never wrap.

## Structure
- Package `lockstep_pkg`: FSM state enum (`RUN`, `DRAIN`, `DONE`) and the default parameter constants.
- Sub-module `lockstep_clk_gate`: negedge enable register plus AND gate, instantiated twice.
- The rest of the logic is flat in `lockstep_pair_ctrl`.

## Test plan
- Reset release with both retire signals low → both core clocks follow `clk_i`; `atk_equiv_o` = 1, `enable_N_o` = 1, `finished_o` = 0.
- `retire_1_i` = 1 for 3 cycles while `retire_2_i` = 0, then both 1 → `clk_1_o` held low 3 cycles; `retire_o` pulses once when both are high; `atk_equiv_o` falls and stays 0.
- Both cores retire in the same cycles for 20 cycles → `retire_o` = 1 on each of those cycles; `atk_equiv_o` stays 1.
- With `INSTR_COUNT` = 16, core 1 fetches at 0x40 (`fetch_1_i` = 1) → `enable_1_o` = 0 next cycle. Core 2 fetches at 0x40 at cycle T → `finished_o` = 1 at T+1+`DRAIN_CYCLES`+1, after which both core clocks stay low.
- `fetch_2_i` = 0 with address 0x80 → `enable_2_o` stays 1.
- Core 2 never retires → `finished_o` = 1 at cycle `MAX_CYCLES`.
- Assert `rst_ni` during DRAIN → all outputs return to reset values immediately, with no clock edge required.
